clk_div_meter: RTL

Measures the period of a slow periodic input, such as a divided clock from the ripple dividers, in cycles of the system clock `clk`. It reports the measured period, flags when the period is stable ("locked"), and flags loss of signal. It sits on the receiving side of a frequency divider and is used in-system to confirm the divide ratio and the presence of the divided clock.

---
 rtl/clk_div_meter_pkg.sv | 17 +
 rtl/sync_edge_det.sv | 35 +++
 rtl/clk_div_meter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/clk_div_meter_pkg.sv
// Shared types and constants for the divided-clock period meter.
package clk_div_meter_pkg;

    typedef enum logic {
        S_WAIT_FIRST = 1'b0,
        S_MEASURE    = 1'b1
    } meter_state_e;

    // Width of the consecutive-match counter; holds LOCK_CNT up to 15.
    localparam int unsigned MATCH_W = 4;

    // Largest value a CNT_W-bit counter can hold (2^CNT_W - 1).
    function automatic longint unsigned cnt_max(input int unsigned cnt_w);
        return (64'd1 << cnt_w) - 64'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a one-cycle rising-edge pulse.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic edge_p
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Shift the asynchronous input through the synchroniser and history flop.
    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchroniser and edge-history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign edge_p = sync2_q & ~prev_q;

endmodule

// File: rtl/clk_div_meter.sv
// Measures the period of a slow input in clk cycles, with lock and loss-of-signal flags.
module clk_div_meter #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TOL      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);
    import clk_div_meter_pkg::*;

    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W:0]     TOL_V   = (CNT_W + 1)'(TOL);
    localparam logic [MATCH_W-1:0] LOCK_V  = MATCH_W'(LOCK_CNT);

    meter_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   prev_q, prev_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               first_q, first_d;
    logic               pv_q, pv_d;
    logic               locked_q, locked_d;
    logic               timeout_q, timeout_d;

    logic               edge_p;
    logic [CNT_W:0]     diff;
    logic               match;

    sync_edge_det u_sync_edge_det (
        .clk    (clk),
        .reset  (reset),
        .d      (sig_in),
        .edge_p (edge_p)
    );

    // Absolute difference between the period just counted and the previous one.
    always_comb begin
        diff  = '0;
        if (cnt_q >= prev_q) begin
            diff = {1'b0, cnt_q} - {1'b0, prev_q};
        end else begin
            diff = {1'b0, prev_q} - {1'b0, cnt_q};
        end
        match = (diff <= TOL_V);
    end

    // Measurement FSM: counter, period capture, lock tracking and timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        prev_d    = prev_q;
        match_d   = match_q;
        first_d   = first_q;
        pv_d      = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        if (!en) begin
            state_d  = S_WAIT_FIRST;
            cnt_d    = '0;
            match_d  = '0;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                S_WAIT_FIRST: begin
                    cnt_d = '0;
                    if (edge_p) begin
                        cnt_d     = CNT_W'(1);
                        state_d   = S_MEASURE;
                        timeout_d = 1'b0;
                        first_d   = 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (edge_p) begin
                        period_d  = cnt_q;
                        pv_d      = 1'b1;
                        cnt_d     = CNT_W'(1);
                        timeout_d = 1'b0;
                        prev_d    = cnt_q;
                        first_d   = 1'b0;
                        if (first_q || !match) begin
                            match_d = '0;
                        end else if (match_q != LOCK_V) begin
                            match_d = match_q + MATCH_W'(1);
                        end
                        locked_d = (match_d == LOCK_V);
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        match_d   = '0;
                        cnt_d     = '0;
                        state_d   = S_WAIT_FIRST;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_WAIT_FIRST;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_WAIT_FIRST;
            cnt_q     <= '0;
            period_q  <= '0;
            prev_q    <= '0;
            match_q   <= '0;
            first_q   <= 1'b0;
            pv_q      <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            prev_q    <= prev_d;
            match_q   <= match_d;
            first_q   <= first_d;
            pv_q      <= pv_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule
